// File: rtl/debug_host_link_if.sv
// Bundle of the command, UART FIFO and response signals of debug_host_link.
// The slave modport is the link itself; the master modport is the host side
// that drives requests and FIFO status and observes responses.
interface debug_host_link_if;
    // Command request handshake
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    // UART transmit byte stream
    logic        tx_fifo_full;
    logic [7:0]  tx_fifo_data;
    logic        tx_fifo_write;
    // UART receive byte stream
    logic        rx_fifo_empty;
    logic [7:0]  rx_fifo_data;
    logic        rx_fifo_read;
    // Decoded responses and status
    logic        rsp_valid;
    logic        rsp_kind;
    logic [6:0]  rsp_tag;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        input  tx_fifo_full, rx_fifo_empty, rx_fifo_data,
        output req_ready, tx_fifo_data, tx_fifo_write, rx_fifo_read,
        output rsp_valid, rsp_kind, rsp_tag, rsp_data, rsp_err, rsp_timeout, busy
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        output tx_fifo_full, rx_fifo_empty, rx_fifo_data,
        input  req_ready, tx_fifo_data, tx_fifo_write, rx_fifo_read,
        input  rsp_valid, rsp_kind, rsp_tag, rsp_data, rsp_err, rsp_timeout, busy
    );
endinterface

// File: rtl/debug_host_link.sv
// debug_host_link: turns read/write commands into ASCII frames on a UART TX
// FIFO ("wAAAA.DDDDDDDD\n" / "qAAAA\n") and decodes "rTT.DDDDDDDD\n" read
// data and "bTT\n" write acks from the RX FIFO.
// Optional build macro DEBUG_HOST_LINK_TIMEOUT_EN adds a 16-bit response
// timeout that releases the encoder after 0xFFFF cycles of waiting.
module debug_host_link (
    input  logic               clk,
    input  logic               rst_n,
    debug_host_link_if.slave   bus
);

    typedef enum logic [1:0] {E_IDLE, E_SEND, E_WAIT} enc_state_e;
    typedef enum logic [2:0] {D_IDLE, D_TAG1, D_TAG0, D_DOT, D_DATA, D_NL} dec_state_e;

    localparam logic [7:0] CH_W   = 8'h77;  // 'w'
    localparam logic [7:0] CH_Q   = 8'h71;  // 'q'
    localparam logic [7:0] CH_R   = 8'h72;  // 'r'
    localparam logic [7:0] CH_B   = 8'h62;  // 'b'
    localparam logic [7:0] CH_DOT = 8'h2E;  // '.'
    localparam logic [7:0] CH_NL  = 8'h0A;  // '\n'

    // Uppercase ASCII for one nibble
    function automatic logic [7:0] nib_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // {valid, nibble} for 0-9, A-F, a-f; valid = 0 for anything else
    function automatic logic [4:0] ascii_to_nib(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)                               return {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) return {1'b1, c[3:0] + 4'd9};
        else                                                        return 5'b0;
    endfunction

    // ---------------- encoder ----------------
    enc_state_e  enc_state_q;
    logic        wr_q;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  idx_q;
    logic [7:0]  frame_byte;
    logic [15:0] addr_sh;
    logic [31:0] data_sh;
    logic [3:0]  last_idx;
    logic        timeout_hit;
    logic        rsp_valid_q;
    logic        rsp_err_q;

    assign last_idx = wr_q ? 4'd14 : 4'd5;

    // Byte of the current frame selected by the byte index
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        frame_byte = CH_NL;
        addr_sh    = addr_q << {idx_q - 4'd1, 2'b00};
        data_sh    = wdata_q << {idx_q - 4'd6, 2'b00};
        if (idx_q == 4'd0)                        frame_byte = wr_q ? CH_W : CH_Q;
        else if (idx_q <= 4'd4)                   frame_byte = nib_to_ascii(addr_sh[15:12]);
        else if (wr_q && idx_q == 4'd5)           frame_byte = CH_DOT;
        else if (wr_q && idx_q <= 4'd13)          frame_byte = nib_to_ascii(data_sh[31:28]);
    end

`ifdef DEBUG_HOST_LINK_TIMEOUT_EN
    logic [15:0] wait_cnt_q;
    assign timeout_hit = (enc_state_q == E_WAIT) && (wait_cnt_q == 16'hFFFF);
`else
    assign timeout_hit = 1'b0;
`endif

    // Encoder FSM: accept a command, stream its frame, wait for the reply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_state_q <= E_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            idx_q       <= '0;
`ifdef DEBUG_HOST_LINK_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            case (enc_state_q)
                E_IDLE: begin
                    if (bus.req_valid) begin
                        wr_q        <= bus.req_wr;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        idx_q       <= '0;
                        enc_state_q <= E_SEND;
                    end
                end
                E_SEND: begin
                    if (!bus.tx_fifo_full) begin
                        if (idx_q == last_idx) begin
                            idx_q       <= '0;
                            enc_state_q <= E_WAIT;
`ifdef DEBUG_HOST_LINK_TIMEOUT_EN
                            wait_cnt_q  <= '0;
`endif
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                E_WAIT: begin
                    if (rsp_valid_q || rsp_err_q || timeout_hit) enc_state_q <= E_IDLE;
`ifdef DEBUG_HOST_LINK_TIMEOUT_EN
                    else wait_cnt_q <= wait_cnt_q + 16'd1;
`endif
                end
                default: enc_state_q <= E_IDLE;
            endcase
        end
    end

    assign bus.req_ready     = (enc_state_q == E_IDLE);
    assign bus.busy          = (enc_state_q != E_IDLE);
    assign bus.tx_fifo_write = (enc_state_q == E_SEND) && !bus.tx_fifo_full;
    assign bus.tx_fifo_data  = (enc_state_q == E_SEND) ? frame_byte : 8'h00;
    assign bus.rsp_timeout   = timeout_hit;

    // ---------------- decoder ----------------
    dec_state_e  dec_state_q;
    logic        kind_q;
    logic [6:0]  tag_sr_q;
    logic [31:0] data_sr_q;
    logic [2:0]  dcnt_q;
    logic        rsp_kind_q;
    logic [6:0]  rsp_tag_q;
    logic [31:0] rsp_data_q;
    logic [4:0]  rx_hex;

    assign bus.rx_fifo_read = !bus.rx_fifo_empty;
    assign rx_hex           = ascii_to_nib(bus.rx_fifo_data);

    // Decoder FSM: parse one received byte per cycle, pulse valid or err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_state_q <= D_IDLE;
            kind_q      <= 1'b0;
            tag_sr_q    <= '0;
            data_sr_q   <= '0;
            dcnt_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_kind_q  <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            if (bus.rx_fifo_read) begin
                case (dec_state_q)
                    D_IDLE: begin
                        if (bus.rx_fifo_data == CH_R) begin
                            kind_q      <= 1'b0;
                            dec_state_q <= D_TAG1;
                        end else if (bus.rx_fifo_data == CH_B) begin
                            kind_q      <= 1'b1;
                            dec_state_q <= D_TAG1;
                        end
                    end
                    D_TAG1: begin
                        if (rx_hex[4]) begin
                            tag_sr_q[6:4] <= rx_hex[2:0];
                            dec_state_q   <= D_TAG0;
                        end else begin
                            rsp_err_q   <= 1'b1;
                            dec_state_q <= D_IDLE;
                        end
                    end
                    D_TAG0: begin
                        if (rx_hex[4]) begin
                            tag_sr_q[3:0] <= rx_hex[3:0];
                            dec_state_q   <= kind_q ? D_NL : D_DOT;
                        end else begin
                            rsp_err_q   <= 1'b1;
                            dec_state_q <= D_IDLE;
                        end
                    end
                    D_DOT: begin
                        if (bus.rx_fifo_data == CH_DOT) begin
                            dcnt_q      <= '0;
                            dec_state_q <= D_DATA;
                        end else begin
                            rsp_err_q   <= 1'b1;
                            dec_state_q <= D_IDLE;
                        end
                    end
                    D_DATA: begin
                        if (rx_hex[4]) begin
                            data_sr_q <= {data_sr_q[27:0], rx_hex[3:0]};
                            dcnt_q    <= dcnt_q + 3'd1;
                            if (dcnt_q == 3'd7) dec_state_q <= D_NL;
                        end else begin
                            rsp_err_q   <= 1'b1;
                            dec_state_q <= D_IDLE;
                        end
                    end
                    D_NL: begin
                        if (bus.rx_fifo_data == CH_NL) begin
                            rsp_valid_q <= 1'b1;
                            rsp_kind_q  <= kind_q;
                            rsp_tag_q   <= tag_sr_q;
                            rsp_data_q  <= kind_q ? 32'h0 : data_sr_q;
                        end else begin
                            rsp_err_q <= 1'b1;
                        end
                        dec_state_q <= D_IDLE;
                    end
                    default: dec_state_q <= D_IDLE;
                endcase
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_kind  = rsp_kind_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_debug_host_link.sv
// Directed bench for debug_host_link: expected TX bytes and responses are
// queued when stimulus is driven and checked as the link produces them.
module tb_debug_host_link;

    typedef struct packed {
        logic        kind;
        logic [6:0]  tag;
        logic [31:0] data;
    } rsp_t;

    logic clk;
    logic rst_n;
    debug_host_link_if bus();

    debug_host_link u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   tx_count = 0;
    int   err_cnt = 0;
    int   to_cnt = 0;
    int   to_cyc = 0;
    int   last_wr_cyc = 0;
    logic [7:0] tx_q[$];
    rsp_t       rsp_q[$];
    int         wr_log[$];
    string      hexs = "0123456789ABCDEF";

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // TX monitor: every written byte must be the next expected one
    always @(negedge clk) begin
        if (bus.tx_fifo_write === 1'b1) begin
            tx_count++;
            last_wr_cyc = cyc;
            wr_log.push_back(cyc);
            if (tx_q.size() == 0) check("tx unexpected byte", {56'h0, bus.tx_fifo_data}, 64'hFFFF);
            else                  check("tx byte", {56'h0, bus.tx_fifo_data}, {56'h0, tx_q.pop_front()});
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (rsp_q.size() == 0) begin
                check("rsp unexpected", 64'h1, 64'h0);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                check("rsp kind", {63'h0, bus.rsp_kind}, {63'h0, e.kind});
                check("rsp tag",  {57'h0, bus.rsp_tag},  {57'h0, e.tag});
                check("rsp data", {32'h0, bus.rsp_data}, {32'h0, e.data});
            end
        end
        if (bus.rsp_err === 1'b1) err_cnt++;
        if (bus.rsp_timeout === 1'b1) begin
            to_cnt++;
            to_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic wr, input logic [15:0] addr, input logic [31:0] data);
        tx_q.push_back(wr ? 8'h77 : 8'h71);
        for (int i = 3; i >= 0; i--) tx_q.push_back(hexs[addr[4*i +: 4]]);
        if (wr) begin
            tx_q.push_back(8'h2E);
            for (int i = 7; i >= 0; i--) tx_q.push_back(hexs[data[4*i +: 4]]);
        end
        tx_q.push_back(8'h0A);
    endtask

    task automatic send_req(input logic wr, input logic [15:0] addr, input logic [31:0] data);
        push_frame(wr, addr, data);
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 20 && bus.req_ready !== 1'b1; i++) tick(1);
        check("req_ready before handshake", {63'h0, bus.req_ready}, 64'h1);
        tick(1);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_tx_drain();
        for (int i = 0; i < 200 && tx_q.size() != 0; i++) tick(1);
        check("tx frame drained", tx_q.size(), 0);
    endtask

    task automatic send_rx(input string s);
        for (int i = 0; i < s.len(); i++) begin
            bus.rx_fifo_empty = 1'b0;
            bus.rx_fifo_data  = s[i];
            tick(1);
        end
        bus.rx_fifo_empty = 1'b1;
        bus.rx_fifo_data  = 8'h00;
    endtask

    task automatic wait_rsp_drain();
        for (int i = 0; i < 20 && rsp_q.size() != 0; i++) tick(1);
        check("rsp queue drained", rsp_q.size(), 0);
    endtask

    initial begin
        int base;
        rst_n             = 1'b1;
        bus.req_valid     = 1'b0;
        bus.req_wr        = 1'b0;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.tx_fifo_full  = 1'b0;
        bus.rx_fifo_empty = 1'b1;
        bus.rx_fifo_data  = '0;
        #1 rst_n = 1'b0;
        #2;
        // Reset state
        check("reset req_ready",   {63'h0, bus.req_ready},     64'h1);
        check("reset busy",        {63'h0, bus.busy},          64'h0);
        check("reset tx_write",    {63'h0, bus.tx_fifo_write}, 64'h0);
        check("reset tx_data",     {56'h0, bus.tx_fifo_data},  64'h0);
        check("reset rsp_valid",   {63'h0, bus.rsp_valid},     64'h0);
        check("reset rsp_err",     {63'h0, bus.rsp_err},       64'h0);
        check("reset rsp_timeout", {63'h0, bus.rsp_timeout},   64'h0);
        check("reset rsp_data",    {32'h0, bus.rsp_data},      64'h0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Write frame, no back-pressure: 15 consecutive bytes
        wr_log.delete();
        send_req(1'b1, 16'h0012, 32'hDEADBEEF);
        check("busy after write accept", {63'h0, bus.busy}, 64'h1);
        check("req_ready low in send",   {63'h0, bus.req_ready}, 64'h0);
        wait_tx_drain();
        tick(1);
        check("write byte count", wr_log.size(), 15);
        if (wr_log.size() == 15) check("write bytes consecutive", wr_log[14] - wr_log[0], 14);
        check("busy in wait", {63'h0, bus.busy}, 64'h1);

        // Read data response releases the encoder
        rsp_q.push_back('{kind: 1'b0, tag: 7'h5A, data: 32'h0BADCAFE});
        send_rx("r5a.0badcafe\n");
        wait_rsp_drain();
        tick(2);
        check("idle after read rsp", {63'h0, bus.req_ready}, 64'h1);
        check("rsp_data held",       {32'h0, bus.rsp_data},  64'h0BADCAFE);

        // Read frame with a 3-cycle stall after byte 2
        base = tx_count;
        send_req(1'b0, 16'hAB00, 32'h0);
        for (int i = 0; i < 50 && tx_count - base < 2; i++) tick(1);
        check("stall point reached", tx_count - base, 2);
        bus.tx_fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall no write",    {63'h0, bus.tx_fifo_write}, 64'h0);
            check("stall data stable", {56'h0, bus.tx_fifo_data},  64'h42);
            @(posedge clk);
            #1;
        end
        bus.tx_fifo_full = 1'b0;
        wait_tx_drain();
        tick(1);
        check("read frame byte count", tx_count - base, 6);

        // Echo then write ack
        rsp_q.push_back('{kind: 1'b1, tag: 7'h3F, data: 32'h0});
        send_rx("qAB00\nb3F\n");
        wait_rsp_drain();
        tick(2);
        check("idle after ack",         {63'h0, bus.req_ready}, 64'h1);
        check("ack rsp_data zero held", {32'h0, bus.rsp_data},  64'h0);

        // Bad hex digit, then a clean ack while the encoder is idle
        send_rx("r1G");
        tick(2);
        check("err pulses after G", err_cnt, 1);
        rsp_q.push_back('{kind: 1'b1, tag: 7'h01, data: 32'h0});
        send_rx("b01\n");
        wait_rsp_drain();
        check("no extra err", err_cnt, 1);
        check("encoder stays idle", {63'h0, bus.busy}, 64'h0);

`ifdef DEBUG_HOST_LINK_TIMEOUT_EN
        // Read with no reply: timeout 65535 cycles after E_WAIT entry
        send_req(1'b0, 16'h1234, 32'h0);
        wait_tx_drain();
        base = last_wr_cyc + 1;
        for (int i = 0; i < 70000 && to_cnt == 0; i++) tick(1);
        check("timeout pulses once", to_cnt, 1);
        check("timeout latency", to_cyc - base, 65535);
        check("req_ready after timeout", {63'h0, bus.req_ready}, 64'h1);
`else
        // Read with no reply: encoder waits indefinitely, no timeout
        send_req(1'b0, 16'h1234, 32'h0);
        wait_tx_drain();
        tick(100);
        check("still waiting", {63'h0, bus.busy}, 64'h1);
        check("no timeout", to_cnt, 0);
        rsp_q.push_back('{kind: 1'b1, tag: 7'h7F, data: 32'h0});
        send_rx("b7F\n");
        wait_rsp_drain();
        tick(2);
        check("idle after late ack", {63'h0, bus.req_ready}, 64'h1);
`endif

        // Reset mid-frame: write stops at once and is not resumed
        base = tx_count;
        send_req(1'b1, 16'hFFFF, 32'h01234567);
        for (int i = 0; i < 50 && tx_count - base < 3; i++) tick(1);
        #1 rst_n = 1'b0;
        #1;
        check("mid-frame reset tx_write", {63'h0, bus.tx_fifo_write}, 64'h0);
        check("mid-frame reset busy",     {63'h0, bus.busy},          64'h0);
        check("mid-frame reset ready",    {63'h0, bus.req_ready},     64'h1);
        tx_q.delete();
        tick(1);
        rst_n = 1'b1;
        base = tx_count;
        tick(20);
        check("frame not resumed", tx_count - base, 0);
        check("final rsp queue empty", rsp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/debug_host_link.md
DEBUG_HOST_LINK -- requirements
Module: debug_host_link

Interface
REQ-001 SHALL have clk input 1 as the single clock; all state rises on posedge clk.
REQ-002 SHALL have rst_n input 1 as the asynchronous active-low reset.
REQ-003 SHALL have req_valid input 1 (command request), req_ready output 1 (request accepted when both high), req_wr input 1 (1 = write, 0 = read), req_addr input 16, req_wdata input 32.
REQ-004 SHALL have tx_fifo_full input 1, tx_fifo_data output 8, tx_fifo_write output 1 (UART transmit byte stream).
REQ-005 SHALL have rx_fifo_empty input 1, rx_fifo_data input 8, rx_fifo_read output 1 (UART receive byte stream).
REQ-006 SHALL have rsp_valid output 1, rsp_kind output 1 (0 = read data 'r', 1 = write ack 'b'), rsp_tag output 7, rsp_data output 32, rsp_err output 1, rsp_timeout output 1, busy output 1.

Function
REQ-007 Encoder states: E_IDLE, E_SEND, E_WAIT; busy = (state != E_IDLE).
REQ-008 req_ready = 1 only in E_IDLE; on handshake, req_wr/req_addr/req_wdata latched and E_SEND entered next cycle.
REQ-009 Write frame, 15 bytes: 'w', 4 addr nibbles MS-first, '.', 8 data nibbles MS-first, 0x0A.
REQ-010 Read frame, 6 bytes: 'q', 4 addr nibbles MS-first, 0x0A.
REQ-011 Nibbles encoded as uppercase ASCII: 0-9 -> 0x30-0x39, 10-15 -> 0x41-0x46.
REQ-012 tx_fifo_write = E_SEND && !tx_fifo_full; byte index advances only on a write; tx_fifo_full stalls with tx_fifo_data held stable.
REQ-013 After the last frame byte is written, E_WAIT entered; E_WAIT -> E_IDLE on the cycle rsp_valid, rsp_err or rsp_timeout pulses.
REQ-014 Decoder: rx_fifo_read = !rx_fifo_empty; every available byte consumed, one per cycle.
REQ-015 Decoder states: D_IDLE, D_TAG1, D_TAG0, D_DOT, D_DATA, D_NL.
REQ-016 D_IDLE: 'r' -> D_TAG1 with kind = 0; 'b' -> D_TAG1 with kind = 1; any other byte (including echoed command text, which never contains 'r' or 'b') ignored.
REQ-017 D_TAG1/D_TAG0: hex nibble shifted into tag (7-bit tag; the upper 3 bits come from D_TAG1); then kind 0 -> D_DOT, kind 1 -> D_NL.
REQ-018 D_DOT requires 0x2E -> D_DATA; D_DATA accepts 8 hex nibbles MS-first into a 32-bit shift register -> D_NL; D_NL requires 0x0A.
REQ-019 Hex decode accepts 0-9, A-F and a-f.
REQ-020 Valid 0x0A in D_NL: rsp_valid pulses 1 cycle the next cycle, with rsp_kind/rsp_tag/rsp_data held until the next frame completes; rsp_data = 0 for kind 1.
REQ-021 A non-hex byte where hex is expected, or a wrong delimiter: rsp_err pulses 1 cycle, decoder returns to D_IDLE, and the offending byte is dropped.
REQ-022 A response arriving while the encoder is in E_IDLE or E_SEND is still reported; it does not alter encoder state except in E_WAIT.

Reset
REQ-023 rst_n low: encoder E_IDLE, decoder D_IDLE, counters 0, all outputs 0 except req_ready = 1; an in-flight frame is abandoned and not resumed.

Configuration
REQ-024 DEBUG_HOST_LINK_TIMEOUT_EN defined: a 16-bit counter clears on entry to E_WAIT and increments each E_WAIT cycle; at 0xFFFF, rsp_timeout pulses 1 cycle and the encoder enters E_IDLE.
REQ-025 DEBUG_HOST_LINK_TIMEOUT_EN undefined: no counter, rsp_timeout tied 0, E_WAIT exits only on rsp_valid or rsp_err.

Verification
REQ-026 Write req addr 0x0012, data 0xDEADBEEF, tx never full -> bytes "w0012.DEADBEEF\n" on 15 consecutive cycles; busy = 1.
REQ-027 Read req addr 0xAB00; tx_fifo_full high for 3 cycles after byte 2 -> "qAB00\n" with no lost or duplicated byte.
REQ-028 rx stream "r5a.0badcafe\n" -> one rsp_valid with kind 0, tag 0x5A, data 0x0BADCAFE; encoder returns to E_IDLE.
REQ-029 rx stream "qAB00\nb3F\n" (echo then ack) -> echo ignored, one rsp_valid with kind 1, tag 0x3F.
REQ-030 rx stream "r1G" -> rsp_err pulse on the 'G' byte, decoder in D_IDLE; a following "b01\n" is decoded correctly.
REQ-031 With DEBUG_HOST_LINK_TIMEOUT_EN, read issued and no rx bytes -> rsp_timeout 65535 cycles after E_WAIT entry, then req_ready = 1; rst_n asserted mid-frame -> tx_fifo_write = 0 immediately.
